// File: rtl/scan_addr_gen.sv
// scan_addr_gen
// Window-centre address generator for the Sobel datapath. After a load it
// walks the (2*BORDER+1)-square kernel centre over every valid interior pixel,
// one position per accepted step request. It drives independent read- and
// write-buffer addresses with separate row strides, in serpentine or raster
// order.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   img_rows, img_cols         image size, sampled on load_initial
//   rd_stride, wr_stride       read/write buffer row pitch, sampled on load_initial
//   initial_addr_r/_w          addresses of the first centre (BORDER,BORDER)
//   raster_mode                0 = serpentine, 1 = raster; sampled on load_initial
//   load_initial               start or restart a scan (highest priority)
//   start_move                 step request
//   addr_r, addr_w             current read/write addresses
//   direction                  next move: 00 none, 01 right, 10 left, 11 down/row-return
//   move_done                  one-cycle pulse per accepted step
//   all_done                   final centre reached, held until next load/reset
//   busy                       scan in progress
//   cfg_err                    last load had dimensions too small for the kernel
//
// Optional feature macro SCAN_POS_EN: adds pos_x/pos_y outputs carrying the
// current centre coordinates.
module scan_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 12,
  parameter int BORDER = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIM_W-1:0]  img_rows,
  input  logic [DIM_W-1:0]  img_cols,
  input  logic [ADDR_W-1:0] rd_stride,
  input  logic [ADDR_W-1:0] wr_stride,
  input  logic [ADDR_W-1:0] initial_addr_r,
  input  logic [ADDR_W-1:0] initial_addr_w,
  input  logic              raster_mode,
  input  logic              load_initial,
  input  logic              start_move,
  output logic [ADDR_W-1:0] addr_r,
  output logic [ADDR_W-1:0] addr_w,
  output logic [1:0]        direction,
  output logic              move_done,
  output logic              all_done,
  output logic              busy,
  output logic              cfg_err
`ifdef SCAN_POS_EN
  ,
  output logic [DIM_W-1:0]  pos_x,
  output logic [DIM_W-1:0]  pos_y
`endif
);

  typedef enum logic [1:0] {IDLE, READY, STEP, DONE} state_t;

  localparam logic [DIM_W-1:0]  BORDER_D  = DIM_W'(BORDER);
  localparam logic [DIM_W-1:0]  BORDER_P1 = DIM_W'(BORDER + 1);
  localparam logic [DIM_W-1:0]  KERNEL    = DIM_W'(2 * BORDER + 1);
  localparam logic [DIM_W-1:0]  ONE_D     = DIM_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  state_t            state, state_next;
  logic [DIM_W-1:0]  x, y, x_next, y_next;
  logic [DIM_W-1:0]  cfg_rows, cfg_cols, cfg_rows_next, cfg_cols_next;
  logic [ADDR_W-1:0] cfg_rd_stride, cfg_wr_stride, cfg_rd_stride_next, cfg_wr_stride_next;
  logic              cfg_raster, cfg_raster_next;
  logic [ADDR_W-1:0] addr_r_next, addr_w_next;
  logic [1:0]        direction_next;
  logic              move_done_next, all_done_next, cfg_err_next;
  logic [DIM_W-1:0]  xmax, ymax, load_xmax, span_m1;
  logic [DIM_W-1:0]  mx, my;
  logic [ADDR_W-1:0] mar, maw;

  assign xmax      = cfg_cols - BORDER_P1;
  assign ymax      = cfg_rows - BORDER_P1;
  assign load_xmax = img_cols - BORDER_P1;
  // Row-return rewinds the column offset accumulated across the row (span-1)
  assign span_m1   = cfg_cols - KERNEL;
  assign busy      = (state == READY) || (state == STEP);

`ifdef SCAN_POS_EN
  assign pos_x = x;
  assign pos_y = y;
`endif

  // Serpentine rows alternate: rows at an even offset from BORDER run
  // rightwards, odd ones leftwards. Raster rows always run rightwards.
  function automatic logic row_is_odd(input logic [DIM_W-1:0] py);
    row_is_odd = ((py - BORDER_D) & ONE_D) != '0;
  endfunction

  // Direction of the move that will leave centre (px,py); the caller
  // handles the final centre separately.
  function automatic logic [1:0] next_dir(input logic [DIM_W-1:0] px,
                                          input logic [DIM_W-1:0] py,
                                          input logic [DIM_W-1:0] pxmax,
                                          input logic             raster);
    if (raster || !row_is_odd(py))
      next_dir = (px == pxmax) ? 2'b11 : 2'b01;
    else
      next_dir = (px == BORDER_D) ? 2'b11 : 2'b10;
  endfunction

  // State and datapath register; everything returns to zero on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      cfg_rows      <= '0;
      cfg_cols      <= '0;
      cfg_rd_stride <= '0;
      cfg_wr_stride <= '0;
      cfg_raster    <= 1'b0;
      addr_r        <= '0;
      addr_w        <= '0;
      direction     <= 2'b00;
      move_done     <= 1'b0;
      all_done      <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      state         <= state_next;
      x             <= x_next;
      y             <= y_next;
      cfg_rows      <= cfg_rows_next;
      cfg_cols      <= cfg_cols_next;
      cfg_rd_stride <= cfg_rd_stride_next;
      cfg_wr_stride <= cfg_wr_stride_next;
      cfg_raster    <= cfg_raster_next;
      addr_r        <= addr_r_next;
      addr_w        <= addr_w_next;
      direction     <= direction_next;
      move_done     <= move_done_next;
      all_done      <= all_done_next;
      cfg_err       <= cfg_err_next;
    end
  end

  // Next-state logic. A load beats everything; otherwise a step is taken
  // only from READY, so the STEP cycle that follows each move is what
  // spaces accepted steps at least two cycles apart.
  always_comb begin
    state_next         = state;
    x_next             = x;
    y_next             = y;
    cfg_rows_next      = cfg_rows;
    cfg_cols_next      = cfg_cols;
    cfg_rd_stride_next = cfg_rd_stride;
    cfg_wr_stride_next = cfg_wr_stride;
    cfg_raster_next    = cfg_raster;
    addr_r_next        = addr_r;
    addr_w_next        = addr_w;
    direction_next     = direction;
    move_done_next     = 1'b0;
    all_done_next      = all_done;
    cfg_err_next       = cfg_err;
    mx                 = x;
    my                 = y;
    mar                = addr_r;
    maw                = addr_w;

    if (load_initial) begin
      cfg_rows_next      = img_rows;
      cfg_cols_next      = img_cols;
      cfg_rd_stride_next = rd_stride;
      cfg_wr_stride_next = wr_stride;
      cfg_raster_next    = raster_mode;
      addr_r_next        = initial_addr_r;
      addr_w_next        = initial_addr_w;
      x_next             = BORDER_D;
      y_next             = BORDER_D;
      all_done_next      = 1'b0;
      direction_next     = 2'b00;
      if (img_cols < KERNEL || img_rows < KERNEL) begin
        cfg_err_next = 1'b1;
        state_next   = DONE;
      end else if (img_cols == KERNEL && img_rows == KERNEL) begin
        cfg_err_next  = 1'b0;
        all_done_next = 1'b1;
        state_next    = DONE;
      end else begin
        // A one-column span starts with a down move rather than a right one
        cfg_err_next   = 1'b0;
        state_next     = READY;
        direction_next = next_dir(BORDER_D, BORDER_D, load_xmax, raster_mode);
      end
    end else if (state == READY && start_move) begin
      case (direction)
        2'b01: begin
          mx  = x + ONE_D;
          mar = addr_r + ONE_A;
          maw = addr_w + ONE_A;
        end
        2'b10: begin
          mx  = x - ONE_D;
          mar = addr_r - ONE_A;
          maw = addr_w - ONE_A;
        end
        default: begin
          my = y + ONE_D;
          if (cfg_raster) begin
            mx  = BORDER_D;
            mar = addr_r + cfg_rd_stride - ADDR_W'(span_m1);
            maw = addr_w + cfg_wr_stride - ADDR_W'(span_m1);
          end else begin
            mar = addr_r + cfg_rd_stride;
            maw = addr_w + cfg_wr_stride;
          end
        end
      endcase
      x_next         = mx;
      y_next         = my;
      addr_r_next    = mar;
      addr_w_next    = maw;
      move_done_next = 1'b1;
      // The last centre is on the bottom row, at whichever end that row runs to
      if (my == ymax && mx == ((cfg_raster || !row_is_odd(my)) ? xmax : BORDER_D)) begin
        all_done_next  = 1'b1;
        direction_next = 2'b00;
        state_next     = DONE;
      end else begin
        direction_next = next_dir(mx, my, xmax, cfg_raster);
        state_next     = STEP;
      end
    end else if (state == STEP) begin
      state_next = READY;
    end
  end

endmodule
